// File: rtl/shift_reg_sequencer_pkg.sv
// Shared encodings for controllers that drive the
// universal load/store shift register.
package shift_reg_sequencer_pkg;

  localparam logic [1:0] CNTRL_STORE = 2'b00;
  localparam logic [1:0] CNTRL_LOAD  = 2'b01;
  localparam logic [1:0] CNTRL_LSH   = 2'b10;
  localparam logic [1:0] CNTRL_RSH   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_CAPT  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_reg.sv
// N-bit universal load/store shift register with
// active-low asynchronous set and clear.
module shift_reg
  import shift_reg_sequencer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         set,
  input  logic         clr,
  input  logic [1:0]   cntrl,
  input  logic [N-1:0] in,
  input  logic         inLS,
  input  logic         inRS,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    unique case (cntrl)
      CNTRL_STORE: q_d = q_q;
      CNTRL_LOAD:  q_d = in;
      CNTRL_LSH:   q_d = {q_q[N-2:0], inLS};
      CNTRL_RSH:   q_d = {inRS, q_q[N-1:1]};
      default:     q_d = q_q;
    endcase
  end

  // clear dominates set when both are asserted
  always_ff @(posedge clk or negedge set or negedge clr) begin
    if (!clr)
      q_q <= '0;
    else if (!set)
      q_q <= '1;
    else
      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Sequences LOAD, count SHIFTs and CAPTURE on the shift
// register; streams shifted-out bits and returns the result.
module shift_reg_sequencer
  import shift_reg_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [N-1:0]  data_in,
  input  logic          dir,
  input  logic [CW-1:0] count,
  input  logic          fill,
  input  logic [N-1:0]  sr_q,
  output logic [1:0]    cntrl,
  output logic [N-1:0]  par_out,
  output logic          inLS,
  output logic          inRS,
  output logic          busy,
  output logic          sout,
  output logic          sout_valid,
  output logic [N-1:0]  result,
  output logic          done
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  result_q, result_d;
  logic          dir_q, dir_d;
  logic          fill_q, fill_d;
  logic          done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          data_d  = data_in;
          dir_d   = dir;
          fill_d  = fill;
          cnt_d   = count;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (cnt_q != '0) ? S_SHIFT : S_CAPT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          state_d = S_CAPT;
      end
      S_CAPT: begin
        result_d = sr_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // sout is the pre-shift edge bit, taken straight from sr_q
  always_comb begin
    cntrl      = CNTRL_STORE;
    sout       = 1'b0;
    sout_valid = 1'b0;
    unique case (state_q)
      S_LOAD:  cntrl = CNTRL_LOAD;
      S_SHIFT: begin
        cntrl      = dir_q ? CNTRL_RSH : CNTRL_LSH;
        sout       = dir_q ? sr_q[0] : sr_q[N-1];
        sout_valid = 1'b1;
      end
      default: cntrl = CNTRL_STORE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign par_out = data_q;
  assign inLS    = fill_q;
  assign inRS    = fill_q;
  assign result  = result_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench for shift_reg_sequencer driving the real
// shift register, with an arithmetic reference model.
module tb_shift_reg_sequencer;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  data_in = '0;
  logic          dir = 1'b0;
  logic [CW-1:0] count = '0;
  logic          fill = 1'b0;
  logic [N-1:0]  sr_q;
  logic [1:0]    cntrl;
  logic [N-1:0]  par_out;
  logic          inLS, inRS, busy;
  logic          sout, sout_valid, done;
  logic [N-1:0]  result;

  shift_reg_sequencer #(.N(N), .CW(CW)) dut (
    .clk(clk), .clr(clr), .start(start),
    .data_in(data_in), .dir(dir), .count(count),
    .fill(fill), .sr_q(sr_q), .cntrl(cntrl),
    .par_out(par_out), .inLS(inLS), .inRS(inRS),
    .busy(busy), .sout(sout), .sout_valid(sout_valid),
    .result(result), .done(done)
  );

  shift_reg #(.N(N)) sr (
    .clk(clk), .set(1'b1), .clr(1'b1),
    .cntrl(cntrl), .in(par_out), .inLS(inLS),
    .inRS(inRS), .q(sr_q)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int compared = 0;
  int mismatched = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [1:0] c;
    logic       b;
    logic [3:0] p;
    logic       f;
  } cyc_t;

  typedef struct {
    logic [3:0] r;
    int         e;
  } done_t;

  cyc_t  exp_cyc [int];
  bit    sout_q [$];
  done_t done_q [$];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_res(
    input logic [3:0] d, input logic dr,
    input int c, input logic f);
    int v, r;
    v = int'(d);
    if (!dr)
      r = ((v << c) | (f ? ((1 << c) - 1) : 0)) & 15;
    else
      r = (v >> c) | (f ? (15 & ~(15 >> c)) : 0);
    return r[3:0];
  endfunction

  function automatic bit model_bit(
    input logic [3:0] d, input logic dr,
    input int i, input logic f);
    if (i >= N) return f;
    return dr ? d[i] : d[N-1-i];
  endfunction

  // monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    if (mon_en && !clr) begin
      int k;
      k = edge_n;
      if (exp_cyc.exists(k)) begin
        chk("ctl", {cntrl, busy, par_out, inLS, inRS},
            {exp_cyc[k].c, exp_cyc[k].b, exp_cyc[k].p,
             exp_cyc[k].f, exp_cyc[k].f});
      end else begin
        chk("idle_ctl", {cntrl, busy, sout_valid}, 0);
      end
      if (sout_valid) begin
        if (sout_q.size() == 0) chk("extra_sout_valid", 1, 0);
        else chk("sout", sout, sout_q.pop_front());
      end
      if (done) begin
        if (done_q.size() == 0) chk("extra_done", 1, 0);
        else begin
          done_t x;
          x = done_q.pop_front();
          chk("result", result, x.r);
          chk("done_edge", k, x.e);
        end
      end
    end
  end

  // issues one job; the DUT is idle at the next edge on entry
  task automatic job(
    input logic [3:0] d, input logic dr,
    input logic [2:0] c, input logic f,
    input bit hold, input logic [3:0] bd, input logic bdr,
    input logic [2:0] bc, input logic bf);
    int e0, ci;
    done_t x;
    data_in = d; dir = dr; count = c; fill = f; start = 1'b1;
    @(posedge clk); #1;
    e0 = edge_n;
    ci = int'(c);
    exp_cyc[e0] = '{c: 2'b01, b: 1'b1, p: d, f: f};
    for (int i = 1; i <= ci; i++)
      exp_cyc[e0 + i] = '{c: {1'b1, dr}, b: 1'b1, p: d, f: f};
    exp_cyc[e0 + ci + 1] = '{c: 2'b00, b: 1'b1, p: d, f: f};
    for (int i = 0; i < ci; i++)
      sout_q.push_back(model_bit(d, dr, i, f));
    x.r = model_res(d, dr, ci, f);
    x.e = e0 + ci + 2;
    done_q.push_back(x);
    start = hold; data_in = bd; dir = bdr; count = bc; fill = bf;
    repeat (ci + 2) @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic rjob(input bit hold);
    job($urandom_range(0, 15), 1'($urandom_range(0, 1)),
        $urandom_range(0, 7), 1'($urandom_range(0, 1)), hold,
        $urandom_range(0, 15), 1'($urandom_range(0, 1)),
        $urandom_range(0, 7), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #1 clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cntrl", cntrl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_sout", {sout_valid, sout}, 0);
    chk("rst_par", {par_out, inLS, inRS}, 0);
    clr = 1'b0;
    mon_en = 1'b1;

    job(4'b1011, 1'b0, 3'd2, 1'b0, 1'b0, 0, 0, 0, 0);
    job(4'b1011, 1'b1, 3'd3, 1'b1, 1'b0, 0, 0, 0, 0);
    job(4'b0110, 1'b0, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    // A holds start high with B's fields; B lands in A's done cycle
    job(4'b1011, 1'b0, 3'd1, 1'b0, 1'b1, 4'b0001, 1'b1, 3'd1, 1'b0);
    job(4'b0001, 1'b1, 3'd1, 1'b0, 1'b0, 0, 0, 0, 0);
    job(4'b1001, 1'b0, 3'd6, 1'b1, 1'b0, 0, 0, 0, 0);

    // abort a count=4 job during its second SHIFT cycle
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    data_in = 4'b1010; dir = 1'b0; count = 3'd4;
    fill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    #1;
    chk("abort_cntrl", cntrl, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 0);
    chk("abort_sout", {sout_valid, sout}, 0);
    chk("abort_par", {par_out, inLS, inRS}, 0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    exp_cyc.delete();
    sout_q.delete();
    done_q.delete();
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    job(4'b0101, 1'b1, 3'd2, 1'b1, 1'b0, 0, 0, 0, 0);

    for (int j = 0; j < 30; j++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
      rjob(1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", sout_q.size() + done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_reg_sequencer.md
Name: shift_reg_sequencer

Overview:
- Control stage that sits directly upstream of the n-bit universal load/store shift register and drives its cntrl, in, inLS and inRS inputs.
- Accepts a job: parallel word, direction, shift count and fill bit. It then sequences one LOAD, count SHIFT cycles and one CAPTURE cycle.
- Emits the bits shifted out serially and returns the final register contents with a done pulse.
- Turns the shift register into a handshaked parallel-to-serial and bit-manipulation engine.

Parameters:
- N, 4, width of the controlled shift register.
- CW, 3, width of the shift-count field; must hold the value N.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  reset, asynchronous, active-high.
- start  input  1  job request; sampled only in IDLE.
- data_in  input  N  parallel word to load.
- dir  input  1  0 = left shift, 1 = right shift.
- count  input  CW  number of shift cycles, from 0 to 2^CW-1.
- fill  input  1  bit shifted into the vacated position.
- sr_q  input  N  current output of the shift register.
- cntrl  output  2  to the shift register: 00 store, 01 load, 10 left, 11 right.
- par_out  output  N  to the shift register's parallel input; equals the latched data.
- inLS  output  1  left-shift serial input; equals the latched fill.
- inRS  output  1  right-shift serial input; equals the latched fill.
- busy  output  1  high in LOAD, SHIFT and CAPT.
- sout  output  1  bit leaving the register this shift cycle.
- sout_valid  output  1  high in every SHIFT cycle.
- result  output  N  registered final contents of the shift register.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.

Behaviour:
- States: IDLE, LOAD, SHIFT, CAPT.
- IDLE:
  - cntrl = 00.
  - If start = 1, latch data_in, dir, count and fill into job registers, load the down-counter with count, and go to LOAD.
- LOAD: one cycle.
  - cntrl = 01; the shift register captures par_out at the end of the cycle.
  - Next state is SHIFT if the latched count is nonzero, otherwise CAPT.
- SHIFT:
  - cntrl = 10 if dir = 0, 11 if dir = 1.
  - sout = sr_q[N-1] for left, sr_q[0] for right; this is the pre-shift bit, combinational from sr_q.
  - The counter decrements each cycle; leave for CAPT when it goes from 1 to 0.
  - Exactly count SHIFT cycles occur. count > N is legal: later bits shifted out are fill bits.
- CAPT: one cycle.
  - cntrl = 00.
  - result is loaded from sr_q at the closing edge; the next state is IDLE.
- done is registered and high for exactly the first IDLE cycle after CAPT. busy is 0 in that cycle.
- Latency: if start is accepted at edge E0, done is high in the cycle after edge E0+count+2.
- A start in the done cycle is accepted, so back-to-back jobs incur no bubble.
- start while busy is ignored; there is no queuing, and the job registers stay stable for the whole job.
- cntrl, sout and sout_valid decode combinationally from the state and job registers; no other outputs are combinational.
- Reset (clr = 1, asynchronous, any state including mid-job):
  - State goes to IDLE and counter = 0.
  - done = 0, result = 0, and the job registers (data, dir, fill) = 0.
  - Consequently cntrl = 00, busy = 0, sout_valid = 0, sout = 0, par_out = 0, inLS = inRS = 0.
  - The aborted job produces no done pulse. The shift register keeps whatever it held.
- Release of clr takes effect at the next clock edge; start is sampled only from then on.

Decomposition:
- Shared package holds:
  - cntrl encodings CNTRL_STORE = 2'b00, CNTRL_LOAD = 2'b01, CNTRL_LSH = 2'b10, CNTRL_RSH = 2'b11.
  - State encodings S_IDLE, S_LOAD, S_SHIFT, S_CAPT.
- The package is also reused by any other controller that drives the shift register.
- No sub-module: the counter is a few lines inside the FSM.
- The bench instantiates the real shift register, with set tied to 1 and clr tied to 1 (both inactive), so that sr_q is driven.

Test Plan:
- Left shift: data_in = 4'b1011, dir = 0, count = 2, fill = 0 -> cntrl sequence 01, 10, 10, 00; sout = 1 then 0; done 4 edges after accept; result = 4'b1100.
- Right shift: data_in = 4'b1011, dir = 1, count = 3, fill = 1 -> sout = 1, 1, 0; result = 4'b1111; sout_valid high for exactly 3 cycles.
- count = 0: data_in = 4'b0110 -> LOAD then CAPT, no SHIFT cycles, sout_valid never high; result = 4'b0110; done 2 edges after accept.
- Back-to-back plus ignored start:
  - Job A is 1011 / left / 1 / fill 0.
  - Hold start high throughout job A, with data changed to 0001 while busy; the latched data must not change.
  - Job B (0001 / right / 1 / fill 0) is accepted in A's done cycle -> result A = 4'b0110, then result B = 4'b0000; both done pulses one cycle wide.
- Overshift: data_in = 4'b1001, dir = 0, count = 6, fill = 1 -> sout = 1, 0, 0, 1, 1, 1; result = 4'b1111.
- Reset mid-job: assert clr asynchronously during the 2nd SHIFT cycle of a count = 4 job -> cntrl = 00, busy = 0 and result = 0 immediately, before any clock edge; no done pulse; the next job runs correctly.
